// File: rtl/fir_tap_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fir_tap_buffer_pkg
// Shared definitions for the FIR tap delay line and its MAC sequencer.
//   fir_addr_w / fir_ch_w / fir_cnt_w : port/counter width helpers
//   ptr_wrap_inc                      : circular pointer increment, any depth
//   tap_index                         : slot holding tap 'address' given wr_ptr
//   rd_status_e                       : classification of a tap read request
// Optional feature macro used by the files of this block: FIR_TAP_SYM_READ_EN
// ---------------------------------------------------------------------------
package fir_tap_buffer_pkg;

    // Read result classification: valid tap, tap not yet written, bad request.
    typedef enum logic [1:0] {
        RD_OK    = 2'd0,
        RD_EMPTY = 2'd1,
        RD_ERR   = 2'd2
    } rd_status_e;

    // Tap address width; at least one bit even for degenerate depths.
    function automatic int fir_addr_w(input int coeff_size);
        int w;
        w = $clog2(coeff_size);
        return (w < 1) ? 1 : w;
    endfunction

    // Channel select width; at least one bit for a single-channel build.
    function automatic int fir_ch_w(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

    // Fill counter width: must represent 0..coeff_size inclusive.
    function automatic int fir_cnt_w(input int coeff_size);
        return $clog2(coeff_size + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths never visit unused slots.
    function automatic int ptr_wrap_inc(input int ptr, input int size);
        return (ptr >= size - 1) ? 0 : ptr + 1;
    endfunction

    // (wr_ptr - 1 - address) mod size. The 2*size bias keeps the dividend
    // non-negative for any address the port width can express.
    function automatic int tap_index(input int wr_ptr, input int address, input int size);
        return (wr_ptr + 2 * size - 1 - address) % size;
    endfunction

endpackage

// File: rtl/fir_tap_buffer_if.sv
// ---------------------------------------------------------------------------
// fir_tap_buffer_if
// Sample-write and tap-read bus of the FIR tap buffer.
//   in_valid/in_channel/in        : sample write strobe, channel, data
//   rd_en/rd_channel/address      : tap read request
//   out_valid/out/addr_err        : registered read result
//   primed                        : per-channel "delay line full" flags
//   out_sym                       : mirrored tap, only with FIR_TAP_SYM_READ_EN
// master = sample source / MAC sequencer side, slave = tap buffer side.
// ---------------------------------------------------------------------------
interface fir_tap_buffer_if
    import fir_tap_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int COEFF_SIZE  = 8,
    parameter int CHANNELS    = 1
);
    localparam int ADDR_W = fir_addr_w(COEFF_SIZE);
    localparam int CH_W   = fir_ch_w(CHANNELS);

    logic                   in_valid;
    logic [CH_W-1:0]        in_channel;
    logic [INPUT_WIDTH-1:0] in;
    logic                   rd_en;
    logic [CH_W-1:0]        rd_channel;
    logic [ADDR_W-1:0]      address;
    logic                   out_valid;
    logic [INPUT_WIDTH-1:0] out;
    logic                   addr_err;
    logic [CHANNELS-1:0]    primed;
`ifdef FIR_TAP_SYM_READ_EN
    logic [INPUT_WIDTH-1:0] out_sym;

    modport master (
        output in_valid, in_channel, in, rd_en, rd_channel, address,
        input  out_valid, out, addr_err, primed, out_sym
    );
    modport slave (
        input  in_valid, in_channel, in, rd_en, rd_channel, address,
        output out_valid, out, addr_err, primed, out_sym
    );
`else
    modport master (
        output in_valid, in_channel, in, rd_en, rd_channel, address,
        input  out_valid, out, addr_err, primed
    );
    modport slave (
        input  in_valid, in_channel, in, rd_en, rd_channel, address,
        output out_valid, out, addr_err, primed
    );
`endif

endinterface

// File: rtl/fir_tap_buffer_bank.sv
// ---------------------------------------------------------------------------
// fir_tap_bank
// One channel of the tap delay line: circular sample store, write pointer,
// saturating fill count and combinational tap read.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data : store one sample at wr_ptr and advance
//   rd_addr        : tap index (0 = newest)
//   rd_data        : raw slot contents for rd_addr (unmasked)
//   rd_hit         : rd_addr < fill, i.e. the tap has been written
//   primed         : fill has reached COEFF_SIZE
//   rd_addr_sym / rd_data_sym / rd_hit_sym : second read port, present only
//                    with FIR_TAP_SYM_READ_EN
// Storage is deliberately not reset; the fill count hides stale slots.
// ---------------------------------------------------------------------------
module fir_tap_bank
    import fir_tap_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int COEFF_SIZE   = 8,
    localparam int ADDR_W      = fir_addr_w(COEFF_SIZE),
    localparam int CNT_W       = fir_cnt_w(COEFF_SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [INPUT_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [INPUT_WIDTH-1:0] rd_data,
    output logic                   rd_hit,
`ifdef FIR_TAP_SYM_READ_EN
    input  logic [ADDR_W-1:0]      rd_addr_sym,
    output logic [INPUT_WIDTH-1:0] rd_data_sym,
    output logic                   rd_hit_sym,
`endif
    output logic                   primed
);

    logic [INPUT_WIDTH-1:0] mem [COEFF_SIZE];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]       fill;
    logic [ADDR_W-1:0]      rd_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            wr_ptr <= ADDR_W'(ptr_wrap_inc(int'(wr_ptr), COEFF_SIZE));
            if (int'(fill) < COEFF_SIZE) begin
                fill <= fill + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Reads use the pre-edge pointer, so a same-cycle write is not visible.
    always_comb begin
        rd_idx  = ADDR_W'(tap_index(int'(wr_ptr), int'(rd_addr), COEFF_SIZE));
        rd_data = mem[rd_idx];
        rd_hit  = int'(rd_addr) < int'(fill);
    end

`ifdef FIR_TAP_SYM_READ_EN
    logic [ADDR_W-1:0] rd_idx_sym;

    always_comb begin
        rd_idx_sym  = ADDR_W'(tap_index(int'(wr_ptr), int'(rd_addr_sym), COEFF_SIZE));
        rd_data_sym = mem[rd_idx_sym];
        rd_hit_sym  = int'(rd_addr_sym) < int'(fill);
    end
`endif

    assign primed = (int'(fill) == COEFF_SIZE);

endmodule

// File: rtl/fir_tap_buffer.sv
// ---------------------------------------------------------------------------
// fir_tap_buffer
// Multi-channel FIR tap delay line. Each channel is a circular buffer
// (fir_tap_bank); samples are written once and taps are read by address
// with one cycle of registered latency.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears pointers, fill counts, outputs
//   bus   : fir_tap_buffer_if.slave (write strobe, tap read, results, primed)
// Optional: FIR_TAP_SYM_READ_EN adds bus.out_sym, the mirrored tap
// COEFF_SIZE-1-address, for a symmetric-FIR pre-adder.
// ---------------------------------------------------------------------------
module fir_tap_buffer
    import fir_tap_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int COEFF_SIZE  = 8,
    parameter int CHANNELS    = 1
) (
    input logic              clock,
    input logic              reset,
    fir_tap_buffer_if.slave  bus
);

    localparam int ADDR_W = fir_addr_w(COEFF_SIZE);
    localparam int CH_W   = fir_ch_w(CHANNELS);

    logic [CHANNELS-1:0]    wr_en;
    logic [CHANNELS-1:0]    bank_hit;
    logic [CHANNELS-1:0]    bank_primed;
    logic [INPUT_WIDTH-1:0] bank_data [CHANNELS];

    logic                   sel_hit;
    logic [INPUT_WIDTH-1:0] sel_data;
    rd_status_e             rd_status;

    logic                   out_valid_q;
    logic [INPUT_WIDTH-1:0] out_q;
    logic                   addr_err_q;

`ifdef FIR_TAP_SYM_READ_EN
    logic [ADDR_W-1:0]      addr_sym;
    logic [CHANNELS-1:0]    bank_hit_sym;
    logic [INPUT_WIDTH-1:0] bank_data_sym [CHANNELS];
    logic                   sel_hit_sym;
    logic [INPUT_WIDTH-1:0] sel_data_sym;
    logic [INPUT_WIDTH-1:0] out_sym_q;

    // Only meaningful when address is in range; otherwise masked by RD_ERR.
    assign addr_sym = ADDR_W'(COEFF_SIZE - 1 - int'(bus.address));
`endif

    // Write demux: an out-of-range channel matches no bank and is dropped.
    always_comb begin
        wr_en = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_en[c] = bus.in_valid && (bus.in_channel == CH_W'(c));
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        fir_tap_bank #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .COEFF_SIZE  (COEFF_SIZE)
        ) u_bank (
            .clock       (clock),
            .reset       (reset),
            .wr_en       (wr_en[c]),
            .wr_data     (bus.in),
            .rd_addr     (bus.address),
            .rd_data     (bank_data[c]),
            .rd_hit      (bank_hit[c]),
`ifdef FIR_TAP_SYM_READ_EN
            .rd_addr_sym (addr_sym),
            .rd_data_sym (bank_data_sym[c]),
            .rd_hit_sym  (bank_hit_sym[c]),
`endif
            .primed      (bank_primed[c])
        );
    end

    // Read mux and request classification.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
`ifdef FIR_TAP_SYM_READ_EN
        sel_data_sym = '0;
        sel_hit_sym  = 1'b0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.rd_channel == CH_W'(c)) begin
                sel_data = bank_data[c];
                sel_hit  = bank_hit[c];
`ifdef FIR_TAP_SYM_READ_EN
                sel_data_sym = bank_data_sym[c];
                sel_hit_sym  = bank_hit_sym[c];
`endif
            end
        end

        if (int'(bus.rd_channel) >= CHANNELS || int'(bus.address) >= COEFF_SIZE) begin
            rd_status = RD_ERR;
        end else if (!sel_hit) begin
            rd_status = RD_EMPTY;
        end else begin
            rd_status = RD_OK;
        end
    end

    // out/addr_err hold their value on cycles without a read request.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            addr_err_q  <= 1'b0;
`ifdef FIR_TAP_SYM_READ_EN
            out_sym_q   <= '0;
`endif
        end else begin
            out_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                out_q      <= (rd_status == RD_OK) ? sel_data : '0;
                addr_err_q <= (rd_status == RD_ERR);
`ifdef FIR_TAP_SYM_READ_EN
                out_sym_q  <= (rd_status != RD_ERR && sel_hit_sym) ? sel_data_sym : '0;
`endif
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.primed    = bank_primed;
`ifdef FIR_TAP_SYM_READ_EN
    assign bus.out_sym   = out_sym_q;
`endif

endmodule
